// File: rtl/tytra_stream_pkg.sv
// Shared definitions for the stream source slice.
//   state_e : FSM encoding for kernel_stream_src (IDLE, RUN, DRAIN, DONE)
//   xfer()  : valid/ready handshake test; a beat moves on the edge where this is 1
package tytra_stream_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_e;

    function automatic logic xfer(input logic valid, input logic ready);
        return valid & ready;
    endfunction

endpackage

// File: rtl/stream_fifo_2w.sv
// Synchronous FIFO holding word pairs for the stream source output side.
// The head entry is read straight out of the storage registers, so dout_o is
// registered and stays stable while the head is not popped.
// Ports:
//   clk      clock, all logic on posedge
//   rst      synchronous active-low reset; empties the FIFO and clears storage
//   push_i   write din_i (accepted when not full, or when full with a pop)
//   din_i    W-bit entry to write
//   pop_i    remove head entry (ignored when empty)
//   dout_o   head entry
//   valid_o  FIFO non-empty
//   count_o  number of stored entries, 0..DEPTH
module stream_fifo_2w #(
    parameter int W     = 64,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic [W-1:0]               din_i,
    input  logic                       pop_i,
    output logic [W-1:0]               dout_o,
    output logic                       valid_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_q;
    logic [PW-1:0] rd_q;
    logic [PW:0]   cnt_q;
    logic          do_push;
    logic          do_pop;

    assign do_pop  = pop_i && (cnt_q != '0);
    // A push into a full FIFO is legal only when the head leaves on the same edge.
    assign do_push = push_i && ((cnt_q != (PW+1)'(DEPTH)) || do_pop);

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_q] <= din_i;
                wr_q        <= wr_q + 1'b1;
            end
            if (do_pop) begin
                rd_q <= rd_q + 1'b1;
            end
            cnt_q <= cnt_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
        end
    end

    assign dout_o  = mem_q[rd_q];
    assign valid_o = (cnt_q != '0);
    assign count_o = cnt_q;

endmodule

// File: rtl/kernel_stream_src.sv
// Stream producer feeding a map kernel's paired input (ivalid/iready/in1/in2).
// On start it reads nwords word pairs from two 1-cycle-latency banks, from
// address base upward, and emits them in order through a credit-managed FIFO.
// Ports:
//   clk, rst              clock; synchronous active-low reset
//   start, base, nwords   job launch (sampled only in IDLE)
//   busy, done            busy in RUN/DRAIN; done pulses for one cycle at the end
//   mem_rden, mem_raddr   read strobe/address shared by both banks
//   mem_rdata1/2          bank data, valid the cycle after mem_rden
//   ovalid, oready        output handshake
//   out1_s0, out2_s0      output pair
module kernel_stream_src
    import tytra_stream_pkg::*;
#(
    parameter int STREAMW = 32,
    parameter int AW      = 10,
    parameter int CNTW    = 16,
    parameter int DEPTH   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [AW-1:0]      base,
    input  logic [CNTW-1:0]    nwords,
    output logic               busy,
    output logic               done,
    output logic               mem_rden,
    output logic [AW-1:0]      mem_raddr,
    input  logic [STREAMW-1:0] mem_rdata1,
    input  logic [STREAMW-1:0] mem_rdata2,
    output logic               ovalid,
    input  logic               oready,
    output logic [STREAMW-1:0] out1_s0,
    output logic [STREAMW-1:0] out2_s0
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 2;

    state_e              state_q, state_d;
    logic [AW-1:0]       base_q, base_d;
    logic [CNTW-1:0]     nwords_q, nwords_d;
    logic [CNTW-1:0]     issued_q, issued_d;
    logic [CNTW-1:0]     emitted_q, emitted_d;
    logic                inflight_q;

    logic                rden;
    logic                pop;
    logic                credit_ok;
    logic [CW-1:0]       occupancy;
    logic [PW:0]         fifo_count;
    logic [2*STREAMW-1:0] fifo_head;

    assign pop = xfer(ovalid, oready);

    // Every outstanding read already owns a FIFO slot, so a returning word
    // can never meet a full FIFO.
    assign occupancy = CW'(fifo_count) + CW'(inflight_q);
    assign credit_ok = occupancy < CW'(DEPTH);

    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        nwords_d  = nwords_q;
        issued_d  = issued_q;
        emitted_d = emitted_q;
        rden      = 1'b0;

        if (pop) begin
            emitted_d = emitted_q + 1'b1;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (nwords != '0) begin
                        state_d   = ST_RUN;
                        base_d    = base;
                        nwords_d  = nwords;
                        issued_d  = '0;
                        emitted_d = '0;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_RUN: begin
                if (issued_q == nwords_q) begin
                    state_d = ST_DRAIN;
                end else if (credit_ok) begin
                    rden     = 1'b1;
                    issued_d = issued_q + 1'b1;
                end
            end
            ST_DRAIN: begin
                // Exit on the edge of the final transfer so done follows it
                // directly; emitted==nwords already implies empty and idle reads.
                if (emitted_d == nwords_q) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            base_q     <= '0;
            nwords_q   <= '0;
            issued_q   <= '0;
            emitted_q  <= '0;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            nwords_q   <= nwords_d;
            issued_q   <= issued_d;
            emitted_q  <= emitted_d;
            inflight_q <= rden;
        end
    end

    stream_fifo_2w #(
        .W     (2*STREAMW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (inflight_q),
        .din_i   ({mem_rdata1, mem_rdata2}),
        .pop_i   (pop),
        .dout_o  (fifo_head),
        .valid_o (ovalid),
        .count_o (fifo_count)
    );

    assign mem_rden  = rden;
    assign mem_raddr = base_q + AW'(issued_q);
    assign busy      = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign done      = (state_q == ST_DONE);
    assign out1_s0   = fifo_head[2*STREAMW-1:STREAMW];
    assign out2_s0   = fifo_head[STREAMW-1:0];

endmodule

// File: tb/tb_kernel_stream_src.sv
module tb_kernel_stream_src;

    localparam int STREAMW = 32;
    localparam int AW      = 8;
    localparam int CNTW    = 16;
    localparam int DEPTH   = 4;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               start = 1'b0;
    logic [AW-1:0]      base = '0;
    logic [CNTW-1:0]    nwords = '0;
    logic               busy;
    logic               done;
    logic               mem_rden;
    logic [AW-1:0]      mem_raddr;
    logic [STREAMW-1:0] mem_rdata1;
    logic [STREAMW-1:0] mem_rdata2;
    logic               ovalid;
    logic               oready = 1'b0;
    logic [STREAMW-1:0] out1_s0;
    logic [STREAMW-1:0] out2_s0;

    always #5 clk = ~clk;

    kernel_stream_src #(
        .STREAMW (STREAMW),
        .AW      (AW),
        .CNTW    (CNTW),
        .DEPTH   (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .base       (base),
        .nwords     (nwords),
        .busy       (busy),
        .done       (done),
        .mem_rden   (mem_rden),
        .mem_raddr  (mem_raddr),
        .mem_rdata1 (mem_rdata1),
        .mem_rdata2 (mem_rdata2),
        .ovalid     (ovalid),
        .oready     (oready),
        .out1_s0    (out1_s0),
        .out2_s0    (out2_s0)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Banks: mem1[a]=a, mem2[a]=a+100; junk when not read so stray pushes show up.
    always @(posedge clk) begin
        if (mem_rden) begin
            mem_rdata1 <= 32'(mem_raddr);
            mem_rdata2 <= 32'(mem_raddr) + 32'd100;
        end else begin
            mem_rdata1 <= 32'hDEAD0000 ^ 32'(cyc);
            mem_rdata2 <= 32'hBEEF0000 ^ 32'(cyc);
        end
    end

    int compared = 0;
    int mismatched = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    logic [63:0]   sb[$];
    logic [AW-1:0] addr_log[$];
    int  rden_cnt, done_cnt, xfer_cnt, busy_cnt;
    int  done_cyc, ov_rise_cyc, first_xfer_cyc, last_xfer_cyc;
    bit  stall_prev = 1'b0;
    bit  ov_prev = 1'b0;
    logic [63:0] held;

    // Monitor: samples on the falling edge, pops the scoreboard on each transfer.
    always @(negedge clk) begin
        if (!rst) begin
            stall_prev = 1'b0;
        end else begin
            if (mem_rden) begin
                rden_cnt++;
                addr_log.push_back(mem_raddr);
            end
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (ovalid && !ov_prev) ov_rise_cyc = cyc;
            if (stall_prev) begin
                chk("hold_valid", 64'(ovalid), 64'd1);
                chk("hold_data", {out1_s0, out2_s0}, held);
            end
            if (ovalid && oready) begin
                if (sb.size() == 0) begin
                    chk("extra_pair_sb_size", 64'(sb.size()), 64'd1);
                end else begin
                    chk("pair", {out1_s0, out2_s0}, sb.pop_front());
                end
                if (xfer_cnt == 0) first_xfer_cyc = cyc;
                last_xfer_cyc = cyc;
                xfer_cnt++;
            end
            stall_prev = ovalid && !oready;
            held = {out1_s0, out2_s0};
        end
        ov_prev = ovalid;
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_stats();
        rden_cnt = 0; done_cnt = 0; xfer_cnt = 0; busy_cnt = 0;
        done_cyc = -1; ov_rise_cyc = -1; first_xfer_cyc = -1; last_xfer_cyc = -1;
        addr_log.delete();
    endtask

    int start_cyc;

    task automatic launch(input logic [AW-1:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            logic [AW-1:0] a;
            a = b + AW'(i);
            sb.push_back({32'(a), 32'(a) + 32'd100});
        end
        base = b;
        nwords = CNTW'(n);
        start = 1'b1;
        start_cyc = cyc;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int lim);
        for (int i = 0; i < lim && done_cnt == 0; i++) tick();
        tick(2);
        chk(name, 64'(done_cnt), 64'd1);
    endtask

    task automatic chk_addrs(input logic [AW-1:0] b, input int n);
        logic [AW-1:0] ea;
        ea = b;
        chk("addr_count", 64'(addr_log.size()), 64'(n));
        for (int i = 0; i < n && i < addr_log.size(); i++) begin
            chk("raddr", 64'(addr_log[i]), 64'(ea));
            ea = ea + 1'b1;
        end
    endtask

    initial begin
        clear_stats();
        // Reset state
        tick(3);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_ovalid", 64'(ovalid), 64'd0);
        chk("rst_rden", 64'(mem_rden), 64'd0);
        chk("rst_raddr", 64'(mem_raddr), 64'd0);
        chk("rst_data", {out1_s0, out2_s0}, 64'd0);
        rst = 1'b1;
        tick(2);

        // 1: basic 4-pair job, full-rate consumer
        clear_stats();
        oready = 1'b1;
        launch(8'h10, 4);
        wait_done("t1_done", 50);
        chk("t1_first_ovalid_latency", 64'(ov_rise_cyc - start_cyc), 64'd3);
        chk("t1_back_to_back", 64'(last_xfer_cyc - first_xfer_cyc), 64'd3);
        chk("t1_done_after_last", 64'(done_cyc - last_xfer_cyc), 64'd1);
        chk("t1_xfers", 64'(xfer_cnt), 64'd4);
        chk_addrs(8'h10, 4);
        chk("t1_sb_empty", 64'(sb.size()), 64'd0);
        tick(2);

        // 2: alternating backpressure
        clear_stats();
        oready = 1'b1;
        launch(8'h40, 8);
        for (int i = 0; i < 300 && done_cnt == 0; i++) begin
            oready = ~oready;
            tick();
        end
        oready = 1'b1;
        tick(2);
        chk("t2_done", 64'(done_cnt), 64'd1);
        chk("t2_xfers", 64'(xfer_cnt), 64'd8);
        chk("t2_sb_empty", 64'(sb.size()), 64'd0);
        tick(2);

        // 3: long stall fills the FIFO, then release
        clear_stats();
        oready = 1'b0;
        launch(8'h80, 16);
        tick(20);
        chk("t3_rden_while_stalled", 64'(rden_cnt), 64'(DEPTH));
        chk("t3_rden_low", 64'(mem_rden), 64'd0);
        chk("t3_ovalid_held", 64'(ovalid), 64'd1);
        oready = 1'b1;
        wait_done("t3_done", 100);
        chk("t3_xfers", 64'(xfer_cnt), 64'd16);
        chk("t3_back_to_back", 64'(last_xfer_cyc - first_xfer_cyc), 64'd15);
        chk("t3_rden_total", 64'(rden_cnt), 64'd16);
        chk("t3_sb_empty", 64'(sb.size()), 64'd0);
        tick(2);

        // 4: empty job
        clear_stats();
        launch(8'h20, 0);
        wait_done("t4_done", 10);
        chk("t4_done_latency", 64'(done_cyc - start_cyc), 64'd1);
        chk("t4_rden", 64'(rden_cnt), 64'd0);
        chk("t4_xfers", 64'(xfer_cnt), 64'd0);
        chk("t4_busy_cycles", 64'(busy_cnt), 64'd0);
        tick(2);

        // 5: address wrap at 2^AW
        clear_stats();
        launch(8'hFE, 4);
        wait_done("t5_done", 50);
        chk_addrs(8'hFE, 4);
        chk("t5_xfers", 64'(xfer_cnt), 64'd4);
        chk("t5_sb_empty", 64'(sb.size()), 64'd0);
        tick(2);

        // 6: reset after the 3rd transfer of a 10-pair job
        clear_stats();
        launch(8'h30, 10);
        for (int i = 0; i < 50 && xfer_cnt < 3; i++) tick();
        chk("t6_reached_3", 64'(xfer_cnt), 64'd3);
        rst = 1'b0;
        tick();
        chk("t6_ovalid_after_rst", 64'(ovalid), 64'd0);
        chk("t6_busy_after_rst", 64'(busy), 64'd0);
        rst = 1'b1;
        sb.delete();
        tick(5);
        chk("t6_no_done", 64'(done_cnt), 64'd0);
        chk("t6_ovalid_idle", 64'(ovalid), 64'd0);
        clear_stats();
        launch(8'h50, 2);
        wait_done("t6_restart_done", 30);
        chk("t6_restart_xfers", 64'(xfer_cnt), 64'd2);
        chk("t6_restart_sb_empty", 64'(sb.size()), 64'd0);
        tick(2);

        // start pulsed mid-run is ignored
        clear_stats();
        launch(8'h60, 10);
        tick(3);
        base = 8'h00;
        nwords = CNTW'(5);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done("t7_done", 60);
        tick(10);
        chk("t7_xfers", 64'(xfer_cnt), 64'd10);
        chk("t7_done_count", 64'(done_cnt), 64'd1);
        chk("t7_rden_total", 64'(rden_cnt), 64'd10);
        chk("t7_busy_end", 64'(busy), 64'd0);
        chk("t7_sb_empty", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
